// File: rtl/fifo_rd_sched.sv
// Round-robin read scheduler: drains N channel FIFOs one word at a time into a
// single valid/ready output, giving each channel at most QUANTUM consecutive
// words per grant before the grant rotates.
//
// Output handshake: out_vld is raised with out_data/out_ch and all three are
// held stable until a cycle in which out_rdy is also high; that cycle is the
// transfer. out_vld is never withdrawn before a transfer.
module fifo_rd_sched #(
  parameter int N       = 4,
  parameter int DW      = 32,
  parameter int QUANTUM = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         fifo_empty,
  output logic [N-1:0]         fifo_rd_en,
  input  logic [N*DW-1:0]      fifo_rdata,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_ch,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 busy,
  output logic [1:0]           dbg_state,
  output logic [$clog2(N)-1:0] dbg_ptr
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] QUANT_C = CW'(QUANTUM);
  localparam logic [PW-1:0] LAST_CH = PW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_vld_q, out_vld_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [PW-1:0]   out_ch_q, out_ch_d;

  logic            pick_vld;
  logic [PW-1:0]   pick;
  logic [PW:0]     cand;
  logic [PW-1:0]   next_ptr;
  logic [N-1:0]    pop;

  // First non-empty channel scanning ptr, ptr+1, ... modulo N.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (PW + 1)'(i);
      if (cand >= (PW + 1)'(N)) cand = cand - (PW + 1)'(N);
      if (!pick_vld && !fifo_empty[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[PW-1:0];
      end
    end
  end

  assign next_ptr = (gnt_q == LAST_CH) ? '0 : gnt_q + PW'(1);

  // Next-state logic; the pop strobe is combinational so it can be qualified
  // by the empty flag of the very same cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    pop        = '0;
    case (state_q)
      IDLE: begin
        if (en && pick_vld) begin
          gnt_d     = pick;
          cnt_d     = '0;
          pop[pick] = 1'b1;
          state_d   = CAPT;
        end
      end
      CAPT: begin
        out_data_d = fifo_rdata[int'(gnt_q)*DW +: DW];
        out_ch_d   = gnt_q;
        out_vld_d  = 1'b1;
        cnt_d      = cnt_q + CW'(1);
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_rdy) begin
          out_vld_d = 1'b0;
          if ((cnt_q < QUANT_C) && !fifo_empty[gnt_q] && en) begin
            pop[gnt_q] = 1'b1;
            state_d    = CAPT;
          end else begin
            ptr_d   = next_ptr;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
    end
  end

  // No pops while reset is held, whatever the FIFOs report.
  assign fifo_rd_en = rst_n ? pop : '0;
  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign dbg_ptr    = ptr_q;

endmodule

// File: doc/fifo_rd_sched.md
# fifo_rd_sched

Round-robin read scheduler draining N request FIFOs into one downstream consumer in the bridge's APB-side clock domain. Owns the read port (`fifo_empty`, `fifo_rd_en`, `fifo_rdata`) of each channel FIFO. Pops one word at a time and presents it with its channel index on a valid/ready output. Each channel gets a bounded burst quantum before the grant rotates, so one busy master cannot starve the others.

## Interface
- `N`, 4: number of FIFO channels, 2..8.
- `DW`, 32: FIFO data width.
- `QUANTUM`, 2: maximum consecutive words taken from one channel per grant, ≥1.
- `clk`  in  1  single clock, same as the FIFOs' read clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `en`  in  1  scheduler enable; gates new grants only.
- `fifo_empty`  in  N  per-channel FIFO empty flag.
- `fifo_rd_en`  out  N  per-channel pop strobe, one-hot or zero.
- `fifo_rdata`  in  N*DW  per-channel read data; channel i is bits [i*DW +: DW].
- `out_data`  out  DW  word presented downstream.
- `out_ch`  out  $clog2(N)  source channel of `out_data`.
- `out_vld`  out  1  `out_data`/`out_ch` valid.
- `out_rdy`  in  1  downstream accepts when high with `out_vld`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FIFO read contract: `fifo_rdata[i]` is valid on the cycle after `fifo_rd_en[i]` is asserted. Each strobe pops exactly one word.
- State: `state` ∈ {IDLE, CAPT, HOLD}, plus the following registers:
  - `ptr` (round-robin start, $clog2(N) bits);
  - `gnt` (current channel);
  - `cnt` (words taken in this grant, 0..QUANTUM).
- IDLE:
  - Condition to start: `en`=1 and at least one channel is non-empty.
  - Select the first non-empty channel scanning `ptr`, `ptr`+1, … modulo N.
  - Set `gnt`, assert `fifo_rd_en[gnt]` for that cycle, set `cnt`=0, go to CAPT.
  - Otherwise stay in IDLE.
- CAPT:
  - Latch `fifo_rdata[gnt]` into `out_data` and `gnt` into `out_ch`.
  - Set `out_vld`=1, set `cnt`=`cnt`+1, go to HOLD.
- HOLD: hold `out_vld`, `out_data` and `out_ch` stable until `out_rdy`=1. On that handshake cycle:
  - If `cnt` < `QUANTUM`, `fifo_empty[gnt]`=0 and `en`=1: assert `fifo_rd_en[gnt]` this cycle, deassert `out_vld`, go to CAPT (burst continue).
  - Else: set `ptr` = (`gnt`+1) mod N, deassert `out_vld`, go to IDLE.
- `fifo_rd_en` is only ever asserted for a channel whose `fifo_empty` is 0 in that same cycle. The scheduler never pops an empty FIFO.
- `en` deasserted:
  - No new grant and no burst continuation.
  - A word already popped is still delivered (CAPT→HOLD→handshake), then the scheduler goes to IDLE.
- Channels that become non-empty mid-burst wait for rotation. There is no preemption.

## Timing
- Reset: `state`=IDLE, `ptr`=0, `gnt`=0, `cnt`=0.
- Output reset values: `fifo_rd_en`=0, `out_vld`=0, `out_data`=0, `out_ch`=0, `busy`=0.
- Reset mid-operation discards any captured word. A word already popped from a FIFO is lost; this is accepted behaviour.
- Latency from IDLE with a non-empty channel:
  - `fifo_rd_en` in cycle t;
  - `out_vld` rises at t+2 (registered, after the CAPT edge).
- Burst throughput with `out_rdy` held high: one word per 2 cycles (HOLD→CAPT→HOLD).
- Grant switch: 3 cycles minimum between words, because IDLE costs one cycle.
- `out_vld` never drops without a handshake (no retraction). `out_data` and `out_ch` never change while `out_vld`=1 and `out_rdy`=0.
- `QUANTUM`=1 gives a strict rotation of one word per grant.
- `ptr` wraps from N-1 to 0. `cnt` never exceeds `QUANTUM`.
- If all channels are empty in HOLD at handshake, the scheduler returns to IDLE with no pop.

## Test plan
- **Reset and idle.** Hold `rst_n`=0 for 3 cycles with all `fifo_empty`=1, then release. Required: every output at its reset value, `busy`=0, and no `fifo_rd_en` for 20 cycles.
- **Single word.**
  - Stimulus: channel 2 holds 0xA5A5A5A5, `en`=1, `out_rdy`=1.
  - Required: `fifo_rd_en`=4'b0100 for 1 cycle; 2 cycles later `out_vld`=1, `out_data`=0xA5A5A5A5, `out_ch`=2; then back to IDLE with `ptr`=3.
- **Quantum and rotation.**
  - Stimulus: channels 0 and 1 hold 3 words each, `QUANTUM`=2, `out_rdy`=1.
  - Required: `out_ch` sequence 0,0,1,1,0,1. Never two strobes in one cycle.
- **Backpressure.**
  - Stimulus: `out_rdy`=0 for 10 cycles after `out_vld` rises.
  - Required: `out_data`/`out_ch` stable, no further `fifo_rd_en`; a single handshake on `out_rdy`=1.
- **Empty mid-burst.**
  - Stimulus: channel 3 holds 1 word, `QUANTUM`=4; channel 0 holds 1 word.
  - Required: one pop from channel 3, no pop attempt while it is empty, then channel 0 served and `ptr` wraps 3→0.
- **Enable and reset mid-op.**
  - Drop `en` in the CAPT cycle. Required: that word delivered, then IDLE with no further pops.
  - Assert `rst_n`=0 while in HOLD. Required: `out_vld`=0 on the next edge.
